// File: rtl/mod64_down_pkg.sv
// mod64_down_pkg: shared widths, limits and types for the mod-64 down counter
// and its 2-bit stages.
package mod64_down_pkg;

    localparam int unsigned CNT_W      = 6;
    localparam int unsigned STAGE_W    = 2;
    localparam int unsigned NUM_STAGES = 3;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [STAGE_W-1:0] stage_t;

    localparam cnt_t   CNT_MAX   = 6'd63;
    localparam stage_t STAGE_MAX = 2'd3;

    // Extract stage k (0 = LSB stage) from a full-width count value.
    function automatic stage_t stage_slice(input cnt_t v, input int unsigned k);
        return v[k*STAGE_W +: STAGE_W];
    endfunction

endpackage

// File: rtl/mod4_down_stage.sv
// mod4_down_stage: one 2-bit down-counting stage of the cascaded counter.
// Ports:
//   clk, reset          - clock, async active-high reset
//   load, load_val      - synchronous load (priority over borrow_in)
//   reset_val           - value forced while reset is asserted
//   borrow_in           - decrement request from the lower stage (or enable)
//   count               - registered stage value
//   borrow_out          - borrow_in & (count == 0), feeds the next stage
module mod4_down_stage
    import mod64_down_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [STAGE_W-1:0] load_val,
    input  logic [STAGE_W-1:0] reset_val,
    input  logic               borrow_in,
    output logic [STAGE_W-1:0] count,
    output logic               borrow_out
);

    // Stage register: reset > load > decrement > hold; 0 wraps to STAGE_MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= reset_val;
        end else if (load) begin
            count <= load_val;
        end else if (borrow_in) begin
            count <= (count == '0) ? STAGE_MAX : count - stage_t'(1);
        end
    end

    assign borrow_out = borrow_in & (count == '0);

endmodule

// File: rtl/mod64_down.sv
// mod64_down: synchronous mod-64 down counter from three cascaded 2-bit stages.
// Loads a start value, decrements on enabled cycles, flags zero and pulses
// borrow for one cycle on the 0 -> 63 wrap.
// Ports:
//   clk, reset     - clock, async active-high reset
//   en             - decrement enable
//   load, load_val - synchronous load (priority over en)
//   count          - registered counter value
//   zero           - combinational count == 0
//   borrow         - registered one-cycle wrap pulse
// Build option: define MOD64_DOWN_HOLD_AT_ZERO_EN to saturate at 0 (borrow
// then never asserts).
module mod64_down
    import mod64_down_pkg::*;
#(
    parameter cnt_t RESET_VAL = CNT_MAX
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero,
    output logic             borrow
);

    // chain[k] is the borrow into stage k; chain[NUM_STAGES] is the full wrap.
    logic [NUM_STAGES:0] chain;

`ifdef MOD64_DOWN_HOLD_AT_ZERO_EN
    // Block decrement at zero; the wrap term can then never assert.
    assign chain[0] = en & (count != '0);
`else
    assign chain[0] = en;
`endif

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        mod4_down_stage u_stage (
            .clk        (clk),
            .reset      (reset),
            .load       (load),
            .load_val   (stage_slice(load_val, k)),
            .reset_val  (stage_slice(RESET_VAL, k)),
            .borrow_in  (chain[k]),
            .count      (count[k*STAGE_W +: STAGE_W]),
            .borrow_out (chain[k+1])
        );
    end

    assign zero = (count == '0);

    // Wrap pulse: load suppresses it, otherwise it follows the top borrow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            borrow <= 1'b0;
        end else if (load) begin
            borrow <= 1'b0;
        end else begin
            borrow <= chain[NUM_STAGES];
        end
    end

endmodule

// File: doc/mod64_down.md
# mod64_down

Synchronous mod-64 down counter built from three cascaded 2-bit down-counting stages, all clocked by `clk`, with no ripple clocking. It is the decrementing counterpart of the team's mod-64 up counter. It serves as a countdown/timeout source: software or control logic loads a start value, and the block decrements on each enabled cycle, flags zero and pulses a borrow on wrap-around.

## Interface
Parameters:
- `RESET_VAL`, default 6'd63: value of `count` while and after `reset` is asserted.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; forces state immediately.
- `en`  input  1  decrement enable, sampled on rising `clk`.
- `load`  input  1  synchronous load strobe; has priority over `en`.
- `load_val`  input  6  value loaded into `count` when `load`=1.
- `count`  output  6  registered counter value; `count[1:0]` is the LSB stage and `count[5:4]` is the MSB stage.
- `zero`  output  1  combinational `count == 0`.
- `borrow`  output  1  registered one-cycle pulse on a 0→63 wrap.

## Operation
- Reset values: `count` = `RESET_VAL`, `borrow` = 0, `zero` = (`RESET_VAL` == 0).
- Priority each rising edge: `reset` > `load` > `en` > hold.
- On `load`: `count` ← `load_val` and `borrow` ← 0, regardless of `en`.
- On `en`, no `load`: `count` ← `count` − 1 modulo 64. If `count` was 0, it becomes 63 and `borrow` ← 1. Otherwise `borrow` ← 0.
- On hold (`en`=0, `load`=0): `count` is unchanged and `borrow` ← 0, so `borrow` never stretches.
- Stage cascade: stage k decrements only when `en` is high and every lower stage is at 0. Stage borrow_out = borrow_in & (stage count == 0). The `borrow` register captures stage 3's borrow_out.
- All arithmetic is unsigned, 6 bits, with no saturation unless the macro below is defined.
- `reset` asserted mid-count takes effect asynchronously with no clock edge. Release resumes counting from `RESET_VAL` on the first edge that sees `en`=1.

## Timing
- Latency: one cycle from an `en` or `load` sample to the new `count`.
- `zero` follows `count` with no register delay.
- `borrow` is high during exactly the cycle in which `count` reads 63 after a wrap.
- `load` and `en` both high: the load wins, no decrement occurs that cycle, and `borrow` = 0.
- `load_val` = 0 with `load`: `zero` goes high next cycle and `borrow` stays low.
- Continuous `en` gives a period of 64 cycles between `borrow` pulses.

## Configuration
- `MOD64_DOWN_HOLD_AT_ZERO_EN` defined:
  - The counter saturates at 0. `en` with `count`=0 holds at 0.
  - `borrow` is tied to 0.
  - `load` still works normally.
- Not defined: wrap 0→63 with the `borrow` pulse, as described above.

## Structure
- Package `mod64_down_pkg` holds:
  - `CNT_W` = 6, `STAGE_W` = 2, `NUM_STAGES` = 3.
  - `CNT_MAX` = 6'd63, `STAGE_MAX` = 2'd3.
  - typedef `cnt_t` (logic [5:0]) and `stage_t` (logic [1:0]).
- Sub-module `mod4_down_stage` is instantiated three times. Its ports are:
  - `clk`, `reset`.
  - `load`, `load_val[1:0]`, `reset_val[1:0]`, `borrow_in`.
  - `count[1:0]`, `borrow_out`.
- The top level chains `borrow_out` of stage k into `borrow_in` of stage k+1. Stage 1 `borrow_in` = `en`.
- The top level also slices `RESET_VAL` and `load_val` per stage and owns the `borrow` register and the saturation gating.

## Test plan
- Reset check: assert `reset` asynchronously between edges with `RESET_VAL`=63 → `count` = 63 immediately, `borrow` = 0, `zero` = 0. Release, hold `en`=0 for 5 cycles → `count` stays 63.
- Full countdown: `load_val`=5 with `load`, then `en`=1 for 6 cycles → `count` reads 5,4,3,2,1,0,63. `zero` is high only at 0, and `borrow` is high only in the cycle showing 63.
- Stage carry: load 16 (6'b010000), one `en` → `count` = 15. Load 4, one `en` → 3. Load 0, one `en` → 63 with `borrow` = 1.
- Simultaneous events: `count`=0, `load`=1 with `load_val`=42 and `en`=1 → next `count` = 42, `borrow` = 0.
- Reset mid-operation: counting at 20 with `en`=1, pulse `reset` for half a cycle → `count` = 63 without an edge. The next enabled edge gives 62.
- Macro build (`MOD64_DOWN_HOLD_AT_ZERO_EN`): load 2, `en`=1 for 5 cycles → `count` reads 2,1,0,0,0. `borrow` stays 0 throughout and `zero` stays 1 from the third cycle on.
